// File: rtl/ext_unit_pipe.sv
// Registered immediate-extension unit: widens IN_W to OUT_W in one of four
// modes and queues results in a 2-entry valid/ready output buffer.
module ext_unit_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam int EXT = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_SIGN   = 2'd1,
    MODE_BRANCH = 2'd2,
    MODE_UPPER  = 2'd3
  } extMode_e;

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_result;
  logic             w_push;
  logic             w_pop;

  logic [OUT_W-1:0] r_data [2];
  logic [1:0]       r_mode [2];
  logic             r_rdPtr;
  logic             r_wrPtr;
  logic [1:0]       r_count;

  assign w_zext = {{EXT{1'b0}}, in_data};
  assign w_sext = {{EXT{in_data[IN_W-1]}}, in_data};

  // Branch mode drops two sign copies off the top; EXT >= 2 keeps every data bit.
  always_comb begin
    w_result = w_zext;
    case (extMode_e'(in_mode))
      MODE_ZERO:   w_result = w_zext;
      MODE_SIGN:   w_result = w_sext;
      MODE_BRANCH: w_result = w_sext << 2;
      MODE_UPPER:  w_result = {in_data, {EXT{1'b0}}};
      default:     w_result = w_zext;
    endcase
  end

  // Flags come only from registered occupancy, so there is no in->out or
  // out_ready->in_ready combinational path.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_data[r_rdPtr];
  assign out_mode  = r_mode[r_rdPtr];

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
      r_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_mode[i] <= 2'd0;
      end
    end else if (flush) begin
      r_rdPtr <= 1'b0;
      r_wrPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_data[r_wrPtr] <= w_result;
        r_mode[r_wrPtr] <= in_mode;
        r_wrPtr         <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Scoreboard bench for ext_unit_pipe: a default 16->32 instance plus an
// 8->12 instance, with hand-computed expected results queued per accepted beat.
module tb_ext_unit_pipe;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_data;
  logic [1:0]  s_in_mode;
  logic        s_out_valid;
  logic [11:0] s_out_data;
  logic [1:0]  s_out_mode;

  logic [33:0] expQ[$];
  logic [13:0] smallQ[$];

  int checks;
  int errors;

  ext_unit_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
  );

  ext_unit_pipe #(.IN_W(8), .OUT_W(12)) dutSmall (
    .clk(clk), .reset_n(reset_n), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_mode(s_in_mode),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data), .out_mode(s_out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Offer one beat and wait (bounded) for acceptance; queue the expected result.
  task automatic applyStimulus(input logic [15:0] data, input logic [1:0] mode,
                               input logic [31:0] expData, output int waited);
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      expQ.push_back({mode, expData});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applySmall(input logic [7:0] data, input logic [1:0] mode,
                            input logic [11:0] expData);
    s_in_valid = 1'b1;
    s_in_data  = data;
    s_in_mode  = mode;
    @(negedge clk);
    checkOutput("small_in_ready", 32'(s_in_ready), 32'd1);
    smallQ.push_back({mode, expData});
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset_n && !flush && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", out_data, 32'hxxxxxxxx);
      end else begin
        checkOutput("out_data", out_data, expQ[0][31:0]);
        checkOutput("out_mode", 32'(out_mode), 32'(expQ[0][33:32]));
        void'(expQ.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && s_out_valid) begin
      if (smallQ.size() == 0) begin
        checkOutput("small_unexpected", {20'd0, s_out_data}, 32'hxxxxxxxx);
      end else begin
        checkOutput("small_out_data", {20'd0, s_out_data}, {20'd0, smallQ[0][11:0]});
        checkOutput("small_out_mode", 32'(s_out_mode), 32'(smallQ[0][13:12]));
        void'(smallQ.pop_front());
      end
    end
  end

  logic [15:0] streamData [8];
  logic [31:0] streamExp  [8];

  initial begin
    int w;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_mode = '0;
    out_ready = 1'b0;
    s_in_valid = 1'b0;
    s_in_data = '0;
    s_in_mode = '0;

    streamData = '{16'h0001, 16'h1234, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0F0F, 16'hA5A5, 16'h5A5A};
    streamExp  = '{32'h00000001, 32'h00001234, 32'h00007FFF, 32'hFFFF8000,
                   32'hFFFFFFFF, 32'h00000F0F, 32'hFFFFA5A5, 32'h00005A5A};

    #12;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_out_mode", 32'(out_mode), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;

    // Four modes on 16'h8001, each visible right after its accepting edge.
    applyStimulus(16'h8001, 2'd1, 32'hFFFF8001, w);
    checkOutput("latency_m1", 32'(out_valid), 32'd1);
    applyStimulus(16'h8001, 2'd0, 32'h00008001, w);
    checkOutput("latency_m0", 32'(out_valid), 32'd1);
    applyStimulus(16'h8001, 2'd2, 32'hFFFE0004, w);
    checkOutput("latency_m2", 32'(out_valid), 32'd1);
    applyStimulus(16'h8001, 2'd3, 32'h80010000, w);
    checkOutput("latency_m3", 32'(out_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: fill both entries and hold the head.
    out_ready = 1'b0;
    applyStimulus(16'h0005, 2'd1, 32'h00000005, w);
    applyStimulus(16'h7FFF, 2'd1, 32'h00007FFF, w);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_out_data", out_data, 32'h00000005);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_pop", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    // Streaming: one beat per cycle, occupancy never reaching 2.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(streamData[i], 2'd1, streamExp[i], w);
      checkOutput("stream_no_stall", 32'(w), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;

    // Flush at count=2 with a beat offered in the same cycle.
    out_ready = 1'b0;
    applyStimulus(16'h1111, 2'd0, 32'h00001111, w);
    applyStimulus(16'h2222, 2'd0, 32'h00002222, w);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hDEAD;
    in_mode = 2'd0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    expQ.delete();
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(16'h0042, 2'd0, 32'h00000042, w);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset mid-cycle with the buffer full.
    out_ready = 1'b0;
    applyStimulus(16'h3333, 2'd1, 32'h00003333, w);
    applyStimulus(16'h4444, 2'd1, 32'h00004444, w);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("areset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("areset_out_data", out_data, 32'd0);
    checkOutput("areset_in_ready", 32'(in_ready), 32'd1);
    expQ.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    applyStimulus(16'hFFFF, 2'd0, 32'h0000FFFF, w);
    repeat (2) @(posedge clk);
    #1;

    // Narrow instance: 8 -> 12 bits.
    applySmall(8'h80, 2'd2, 12'hE00);
    applySmall(8'h80, 2'd3, 12'h800);
    applySmall(8'h80, 2'd1, 12'hF80);
    applySmall(8'h80, 2'd0, 12'h080);

    for (int i = 0; i < 20 && (expQ.size() != 0 || smallQ.size() != 0); i++) begin
      @(posedge clk);
    end
    #1;
    checkOutput("drain_main", 32'(expQ.size()), 32'd0);
    checkOutput("drain_small", 32'(smallQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
